// File: rtl/ascon_perm_ctrl_if.sv
// Register-block / round-unit bus of the ASCON permutation sequencer.
// The slave modport is the sequencer; master is the register file plus round datapath.
interface ascon_perm_ctrl_if #(
   parameter int CNT_W = 4
);
   logic                   start_i;
   logic                   abort_i;
   logic [CNT_W-1:0]       rounds_i;
   logic [4:0][63:0]       state_i;
   logic [4:0][63:0]       state_o;
   logic                   update_state_o;
   logic                   finished_o;
   logic                   busy_o;
   logic [4:0][63:0]       round_state_o;
   logic [7:0]             round_const_o;
   logic [4:0][63:0]       round_state_i;

   modport slave (
      input  start_i, abort_i, rounds_i, state_i, round_state_i,
      output state_o, update_state_o, finished_o, busy_o,
             round_state_o, round_const_o
   );

   modport master (
      output start_i, abort_i, rounds_i, state_i, round_state_i,
      input  state_o, update_state_o, finished_o, busy_o,
             round_state_o, round_const_o
   );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// ASCON permutation sequencer: latches the state, steps an external round unit
// for n rounds with the matching round constants, then strobes the result back.
//
//   state | meaning
//   IDLE  | waiting for a start rising edge
//   RUN   | one round per cycle, state reg takes the round unit result
//   DONE  | one cycle of update/finished, then back to IDLE
module ascon_perm_ctrl #(
   parameter int MAX_ROUNDS = 12,
   parameter int CNT_W      = 4
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   ascon_perm_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_ROUNDS);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   fsm_t               fsm_q;
   logic [4:0][63:0]   st_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   n_q;
   logic               start_q;
   logic               busy_q;
   logic               upd_q;
   logic               fin_q;
   logic [7:0]         rc_q;

   logic               start_evt;
   logic [CNT_W-1:0]   n_dec;
   logic [CNT_W-1:0]   cnt_nxt;

   assign start_evt = bus.start_i & ~start_q;
   assign n_dec     = (bus.rounds_i == '0 || bus.rounds_i > MAX_N) ? MAX_N : bus.rounds_i;
   assign cnt_nxt   = cnt_q + ONE;

   // Constant index runs from MAX_ROUNDS-n up to MAX_ROUNDS-1, so short
   // permutations use the tail of the full-permutation constant sequence.
   function automatic logic [7:0] rc_of(input logic [CNT_W-1:0] n,
                                        input logic [CNT_W-1:0] k);
      logic [CNT_W-1:0] idx;
      logic [3:0]       lo;
      idx = MAX_N - n + k;
      lo  = 4'(idx);
      return {4'hF - lo, lo};
   endfunction

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         fsm_q   <= IDLE;
         st_q    <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         upd_q   <= 1'b0;
         fin_q   <= 1'b0;
         rc_q    <= 8'h00;
      end else begin
         start_q <= bus.start_i;
         case (fsm_q)
            IDLE: begin
               if (start_evt && !bus.abort_i) begin
                  st_q   <= bus.state_i;
                  cnt_q  <= '0;
                  n_q    <= n_dec;
                  rc_q   <= rc_of(n_dec, '0);
                  busy_q <= 1'b1;
                  fsm_q  <= RUN;
               end
            end
            RUN: begin
               if (bus.abort_i) begin
                  rc_q   <= 8'h00;
                  busy_q <= 1'b0;
                  fsm_q  <= IDLE;
               end else begin
                  st_q  <= bus.round_state_i;
                  cnt_q <= cnt_nxt;
                  if (cnt_q == n_q - ONE) begin
                     rc_q  <= 8'h00;
                     upd_q <= 1'b1;
                     fin_q <= 1'b1;
                     fsm_q <= DONE;
                  end else begin
                     rc_q <= rc_of(n_q, cnt_nxt);
                  end
               end
            end
            DONE: begin
               upd_q  <= 1'b0;
               fin_q  <= 1'b0;
               busy_q <= 1'b0;
               fsm_q  <= IDLE;
            end
            default: begin
               rc_q   <= 8'h00;
               upd_q  <= 1'b0;
               fin_q  <= 1'b0;
               busy_q <= 1'b0;
               fsm_q  <= IDLE;
            end
         endcase
      end
   end

   assign bus.state_o        = st_q;
   assign bus.round_state_o  = st_q;
   assign bus.round_const_o  = rc_q;
   assign bus.busy_o         = busy_q;
   assign bus.update_state_o = upd_q;
   assign bus.finished_o     = fin_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Randomized directed bench for ascon_perm_ctrl with a toy round function and
// a reference permutation computed from the round-constant rule.
module tb_ascon_perm_ctrl;

   typedef logic [4:0][63:0] st_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ascon_perm_ctrl_if ifc ();

   ascon_perm_ctrl u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (ifc.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] full_tbl [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

   // Toy round: constant into word 2, plus order-sensitive mixing.
   function automatic st_t round_fn(input st_t x, input logic [7:0] c);
      st_t y;
      y    = x;
      y[2] = x[2] ^ {56'h0, c};
      y[0] = {x[0][62:0], x[0][63]} ^ x[2];
      y[4] = x[4] + x[3];
      return y;
   endfunction

   always_comb ifc.round_state_i = round_fn(ifc.round_state_o, ifc.round_const_o);

   function automatic int eff_rounds(input int r);
      return (r >= 1 && r <= 12) ? r : 12;
   endfunction

   function automatic logic [7:0] ref_const(input int n, input int k);
      int i;
      i = 12 - n + k;
      return 8'((15 - i) * 16 + i);
   endfunction

   function automatic st_t rand_state();
      st_t x;
      for (int w = 0; w < 5; w++) x[w] = {$urandom, $urandom};
      return x;
   endfunction

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 320'(ifc.busy_o), 320'(1'b0));
      chk({tag, "_upd"},  320'(ifc.update_state_o), 320'(1'b0));
      chk({tag, "_fin"},  320'(ifc.finished_o), 320'(1'b0));
      chk({tag, "_rc"},   320'(ifc.round_const_o), 320'(8'h00));
   endtask

   // Full run; toggle_at >= 0 drops start in that RUN cycle and raises it again in the next.
   task automatic run(input int r, input int toggle_at);
      int  n;
      st_t exp;
      n = eff_rounds(r);
      exp = rand_state();
      ifc.state_i  = exp;
      ifc.rounds_i = 4'(r);
      ifc.start_i  = 1'b1;
      @(posedge clk);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("run_busy", 320'(ifc.busy_o), 320'(1'b1));
         chk("run_rc", 320'(ifc.round_const_o), 320'(ref_const(n, k)));
         if (n == 12) chk("run_rc_tbl", 320'(ifc.round_const_o), 320'(full_tbl[k]));
         chk("run_fin", 320'(ifc.finished_o), 320'(1'b0));
         chk("run_upd", 320'(ifc.update_state_o), 320'(1'b0));
         chk("run_rstate", ifc.round_state_o, exp);
         exp = round_fn(exp, ref_const(n, k));
         ifc.state_i  = rand_state();
         ifc.rounds_i = 4'($urandom_range(0, 15));
         if (toggle_at >= 0) begin
            if (k == toggle_at) ifc.start_i = 1'b0;
            if (k == toggle_at + 1) ifc.start_i = 1'b1;
         end else if (k == 1) begin
            ifc.start_i = 1'b0;
         end
      end
      @(negedge clk);
      chk("done_upd", 320'(ifc.update_state_o), 320'(1'b1));
      chk("done_fin", 320'(ifc.finished_o), 320'(1'b1));
      chk("done_busy", 320'(ifc.busy_o), 320'(1'b1));
      chk("done_state", ifc.state_o, exp);
      ifc.start_i = 1'b0;
      @(negedge clk);
      chk_idle("post");
      chk("post_state", ifc.state_o, exp);
   endtask

   int fin_cnt;

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.start_i  = 1'b0;
      ifc.abort_i  = 1'b0;
      ifc.rounds_i = '0;
      ifc.state_i  = '0;
      #1;
      chk_idle("reset");
      chk("reset_state", ifc.state_o, '0);
      chk("reset_rstate", ifc.round_state_o, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("idle0");

      run(12, -1);
      run(6, -1);
      run(8, -1);
      run(0, -1);
      run(15, -1);
      run(1, -1);
      for (int t = 0; t < 4; t++) run(int'($urandom_range(0, 15)), -1);
      run(12, 3);

      // start held high: a single run only
      ifc.rounds_i = 4'd3;
      ifc.start_i  = 1'b1;
      fin_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ifc.finished_o) fin_cnt++;
      end
      chk("held_fin_count", 320'(fin_cnt), 320'(1));
      ifc.start_i = 1'b0;
      @(negedge clk);
      chk_idle("held_end");

      // abort in IDLE blocks a simultaneous start
      ifc.abort_i = 1'b1;
      ifc.start_i = 1'b1;
      @(negedge clk);
      chk("abort_idle_busy", 320'(ifc.busy_o), 320'(1'b0));
      ifc.abort_i = 1'b0;
      @(negedge clk);
      chk("abort_idle_busy2", 320'(ifc.busy_o), 320'(1'b0));
      ifc.start_i = 1'b0;
      @(negedge clk);

      // abort in the 5th RUN cycle
      ifc.state_i  = rand_state();
      ifc.rounds_i = 4'd12;
      ifc.start_i  = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("abort_rc", 320'(ifc.round_const_o), 320'(ref_const(12, k)));
      end
      ifc.abort_i = 1'b1;
      @(negedge clk);
      chk_idle("abort");
      ifc.abort_i = 1'b0;
      ifc.start_i = 1'b0;
      fin_cnt = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (ifc.finished_o || ifc.update_state_o || ifc.busy_o) fin_cnt++;
      end
      chk("abort_quiet", 320'(fin_cnt), 320'(0));
      run(8, -1);

      // reset in the middle of a run
      ifc.state_i  = rand_state();
      ifc.rounds_i = 4'd10;
      ifc.start_i  = 1'b1;
      @(posedge clk);
      repeat (5) @(negedge clk);
      chk("prerst_busy", 320'(ifc.busy_o), 320'(1'b1));
      rst_n = 1'b0;
      #1;
      chk_idle("midrst");
      chk("midrst_state", ifc.state_o, '0);
      chk("midrst_rstate", ifc.round_state_o, '0);
      ifc.start_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      fin_cnt = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (ifc.finished_o || ifc.update_state_o || ifc.busy_o) fin_cnt++;
      end
      chk("rst_quiet", 320'(fin_cnt), 320'(0));
      run(5, -1);
      run(12, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
